ct_intersection_monitor: RTL

Road-side counterpart to the highway/country-road traffic light controller. It sits between the country-road vehicle loops and the controller. It debounces arrivals, keeps a saturating queue count, and drives `ct_sensor` back to the controller. It also watches the `hwy_light`/`ct_light` codes the controller emits and flags protocol violations: conflicting greens, illegal codes, bad sequences, short yellows and red-running.

---
 rtl/traffic_pkg.sv | 60 ++++++
 rtl/light_seq_checker.sv | 76 +++++++
 rtl/ct_intersection_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the highway / country-road intersection.
//   - Light codes driven by the traffic controller (RED, GREEN, YELLOW; 3 is
//     never a legal code).
//   - Violation codes reported by the intersection monitor, lowest non-zero
//     value has the highest priority.
//   - State encoding for the per-light sequence checker, plus two helpers
//     that map a light code to a checker state and give the legal successor.
// No ports (package).
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        RED          = 2'd0,
        GREEN        = 2'd1,
        YELLOW       = 2'd2,
        ILLEGAL_CODE = 2'd3
    } lightCode_e;

    typedef enum logic [2:0] {
        VIOL_NONE         = 3'd0,
        VIOL_CONFLICT     = 3'd1,
        VIOL_ILLEGAL      = 3'd2,
        VIOL_BAD_SEQ      = 3'd3,
        VIOL_SHORT_YELLOW = 3'd4,
        VIOL_RUN_RED      = 3'd5
    } violCode_e;

    typedef enum logic [1:0] {
        CHK_INIT   = 2'd0,
        CHK_RED    = 2'd1,
        CHK_GREEN  = 2'd2,
        CHK_YELLOW = 2'd3
    } chkState_e;

    // Only called for legal codes; the illegal code is filtered by the caller.
    function automatic chkState_e lightToState(input logic [1:0] code);
        chkState_e s;
        case (code)
            RED:     s = CHK_RED;
            GREEN:   s = CHK_GREEN;
            default: s = CHK_YELLOW;
        endcase
        return s;
    endfunction

    // The one state (besides holding) that a light may move to next.
    function automatic chkState_e legalNext(input chkState_e cur);
        chkState_e s;
        case (cur)
            CHK_RED:    s = CHK_GREEN;
            CHK_GREEN:  s = CHK_YELLOW;
            CHK_YELLOW: s = CHK_RED;
            default:    s = CHK_INIT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// ----------------------------------------------------------------------------
// light_seq_checker
// Watches one light code stream and flags sequence problems for the sample
// currently on light_i (flags are combinational; the caller registers them).
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   light_i [1:0]    light code sampled every cycle
//   illegal_o        code 3 seen this cycle
//   badSeq_o         change that is not RED->GREEN->YELLOW->RED
//   shortYellow_o    YELLOW left after fewer than MIN_YELLOW yellow samples
// ----------------------------------------------------------------------------
module light_seq_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light_i,
    output logic       illegal_o,
    output logic       badSeq_o,
    output logic       shortYellow_o
);

    localparam int DWELL_W = $clog2(MIN_YELLOW + 1);
    localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_YELLOW);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    chkState_e          state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // State and yellow-dwell registers; INIT means "no history yet".
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CHK_INIT;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Next state and violation flags. An illegal code freezes everything so
    // the checker keeps judging against the last legal light. A bad change is
    // still adopted so one glitch is reported once, not on every later sample.
    // The dwell counter counts yellow samples and saturates at MIN_YELLOW,
    // which is all the short-yellow check needs to know.
    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        illegal_o     = 1'b0;
        badSeq_o      = 1'b0;
        shortYellow_o = 1'b0;
        if (light_i == ILLEGAL_CODE) begin
            illegal_o = 1'b1;
        end else begin
            state_d = lightToState(light_i);
            if (state_q != CHK_INIT) begin
                if (state_d != state_q && state_d != legalNext(state_q)) begin
                    badSeq_o = 1'b1;
                end
                if (state_q == CHK_YELLOW && state_d != CHK_YELLOW && dwell_q < DWELL_MIN) begin
                    shortYellow_o = 1'b1;
                end
            end
            if (state_d != CHK_YELLOW) begin
                dwell_d = '0;
            end else if (state_q != CHK_YELLOW) begin
                dwell_d = DWELL_ONE;
            end else if (dwell_q < DWELL_MIN) begin
                dwell_d = dwell_q + DWELL_ONE;
            end
        end
    end

endmodule

// File: rtl/ct_intersection_monitor.sv
// ----------------------------------------------------------------------------
// ct_intersection_monitor
// Country-road side of the intersection: debounces vehicle arrivals, keeps a
// saturating queue count that drives ct_sensor, and watches the controller's
// light codes for protocol violations, latching the first one seen.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   hwy_light, ct_light   light codes from the controller
//   car_arrive_raw        raw, asynchronous, bouncy arrival loop
//   car_depart            one-cycle pulse per departing vehicle
//   viol_clear            clears the sticky violation
//   ct_sensor             queue non-empty
//   queue_count           vehicles waiting
//   viol, viol_code       sticky violation flag and first captured code
// ----------------------------------------------------------------------------
module ct_intersection_monitor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int QUEUE_W         = 4,
    parameter int MIN_YELLOW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         hwy_light,
    input  logic [1:0]         ct_light,
    input  logic               car_arrive_raw,
    input  logic               car_depart,
    input  logic               viol_clear,
    output logic               ct_sensor,
    output logic [QUEUE_W-1:0] queue_count,
    output logic               viol,
    output logic [2:0]         viol_code
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE    = DB_W'(1);
    localparam logic [QUEUE_W-1:0] QUEUE_MAX = '1;
    localparam logic [QUEUE_W-1:0] QUEUE_ONE = QUEUE_W'(1);

    logic               sync1_q, sync2_q;
    logic [DB_W-1:0]    dbCount_q, dbCount_d;
    logic               dbLevel_q, dbLevel_d, dbLevelDly_q;
    logic               arrive;
    logic [QUEUE_W-1:0] queue_q, queue_d;
    logic               hwyIllegal, hwyBadSeq, hwyShort;
    logic               ctIllegal, ctBadSeq, ctShort;
    logic               conflict, runRed;
    violCode_e          newCode;
    logic               viol_q, viol_d;
    logic [2:0]         code_q, code_d;

    light_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) hwyChecker (
        .clk           (clk),
        .reset         (reset),
        .light_i       (hwy_light),
        .illegal_o     (hwyIllegal),
        .badSeq_o      (hwyBadSeq),
        .shortYellow_o (hwyShort)
    );

    light_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) ctChecker (
        .clk           (clk),
        .reset         (reset),
        .light_i       (ct_light),
        .illegal_o     (ctIllegal),
        .badSeq_o      (ctBadSeq),
        .shortYellow_o (ctShort)
    );

    // All registered state: two-flop synchronizer on the raw loop, debounce
    // counter and level (plus a delayed copy for edge detection), the queue
    // and the sticky violation capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dbCount_q    <= '0;
            dbLevel_q    <= 1'b0;
            dbLevelDly_q <= 1'b0;
            queue_q      <= '0;
            viol_q       <= 1'b0;
            code_q       <= VIOL_NONE;
        end else begin
            sync1_q      <= car_arrive_raw;
            sync2_q      <= sync1_q;
            dbCount_q    <= dbCount_d;
            dbLevel_q    <= dbLevel_d;
            dbLevelDly_q <= dbLevel_q;
            queue_q      <= queue_d;
            viol_q       <= viol_d;
            code_q       <= code_d;
        end
    end

    // Debounce: count consecutive synchronized samples that disagree with the
    // current level; flip the level once DEBOUNCE_CYCLES of them are seen.
    // Any agreeing sample restarts the count, so both edges need a clean run.
    always_comb begin
        dbCount_d = dbCount_q;
        dbLevel_d = dbLevel_q;
        if (sync2_q != dbLevel_q) begin
            if (dbCount_q == DB_LAST) begin
                dbLevel_d = sync2_q;
                dbCount_d = '0;
            end else begin
                dbCount_d = dbCount_q + DB_ONE;
            end
        end else begin
            dbCount_d = '0;
        end
    end

    assign arrive = dbLevel_q & ~dbLevelDly_q;

    // Queue count: saturates at both ends; a simultaneous arrival and
    // departure cancel out.
    always_comb begin
        queue_d = queue_q;
        if (arrive && !car_depart && queue_q != QUEUE_MAX) begin
            queue_d = queue_q + QUEUE_ONE;
        end else if (car_depart && !arrive && queue_q != '0) begin
            queue_d = queue_q - QUEUE_ONE;
        end
    end

    assign queue_count = queue_q;
    assign ct_sensor   = (queue_q != '0);

    // Cross checks. An illegal code on either light is reported as ILLEGAL
    // only, never also as a conflicting green.
    assign conflict = (hwy_light != RED) && (ct_light != RED) &&
                      (hwy_light != ILLEGAL_CODE) && (ct_light != ILLEGAL_CODE);
    assign runRed   = car_depart && (ct_light == RED);

    // Priority encode this cycle's violations, then capture: the first one
    // sticks until cleared, and a violation arriving together with a clear
    // wins over the clear.
    always_comb begin
        newCode = VIOL_NONE;
        if (conflict) begin
            newCode = VIOL_CONFLICT;
        end else if (hwyIllegal || ctIllegal) begin
            newCode = VIOL_ILLEGAL;
        end else if (hwyBadSeq || ctBadSeq) begin
            newCode = VIOL_BAD_SEQ;
        end else if (hwyShort || ctShort) begin
            newCode = VIOL_SHORT_YELLOW;
        end else if (runRed) begin
            newCode = VIOL_RUN_RED;
        end

        viol_d = viol_q;
        code_d = code_q;
        if (newCode != VIOL_NONE && (!viol_q || viol_clear)) begin
            viol_d = 1'b1;
            code_d = newCode;
        end else if (viol_clear) begin
            viol_d = 1'b0;
            code_d = VIOL_NONE;
        end
    end

    assign viol      = viol_q;
    assign viol_code = code_q;

endmodule
